reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameter ROB_DEPTH, default 16, number of entries; fixed at 16, a power of two.
REQ-002 Parameter TAG_W, default 4, entry tag width; equal to log2(ROB_DEPTH).
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 rdy  input  1  global ready; low freezes all state.
REQ-006 disp_valid  input  1  decoder presents an instruction this cycle.
REQ-007 disp_kind  input  2  0=register write, 1=store, 2=branch, 3=reserved (treated as register write).
REQ-008 disp_rd  input  5  destination register.
REQ-009 disp_pred_taken  input  1  predictor outcome for a branch.
REQ-010 disp_alt_pc  input  32  recovery PC for a branch, used if the prediction is wrong.
REQ-011 disp_accept  output  1  combinational; dispatch taken this cycle (drives decoder "success").
REQ-012 rob_tail  output  TAG_W  tag the next dispatched entry receives.
REQ-013 cdb_valid / cdb_tag / cdb_value / cdb_taken  input  1/TAG_W/32/1  execution result broadcast.
REQ-014 commit_valid  output  1  registered one-cycle pulse; a register write retires.
REQ-015 commit_addr / commit_value / commit_tag  output  5/32/TAG_W  retiring register write.
REQ-016 store_commit / store_tag  output  1/TAG_W  registered one-cycle pulse; the head store retires.
REQ-017 clr / redirect_pc  output  1/32  registered one-cycle flush pulse and the fetch redirect target.

Function
REQ-018 Circular buffer state: head, tail (TAG_W bits, wrap modulo 16), count (0..16); per entry: busy, done, kind, rd, value, pred_taken, actual_taken, alt_pc.
REQ-019 disp_accept = disp_valid & rdy & rst & (count<16) & ~clr.
REQ-020 On accept: write entry[tail] with busy=1, done=0, then tail <= tail+1; rob_tail always shows the current tail.
REQ-021 When cdb_valid is high and entry[cdb_tag] is busy: set done=1 and capture value and actual_taken; ignore the broadcast when the entry is not busy.
REQ-022 Retire at most one entry per edge: the head retires when count>0 and entry[head] is busy and done.
REQ-023 Register-write retire: commit_valid=1, commit_addr=rd, commit_value=value, commit_tag=head for exactly one cycle; rd=0 still pulses.
REQ-024 Store retire: store_commit=1, store_tag=head for one cycle; commit_valid stays 0.
REQ-025 Branch retire with actual_taken==pred_taken: no output pulses; the entry is freed.
REQ-026 Branch retire with a mismatch: clr=1 and redirect_pc=alt_pc for one cycle; head, tail and count go to 0; every busy bit clears; a dispatch in that same cycle is discarded.
REQ-027 Latency: an entry done at dispatch edge E... CDB sampled at edge E makes the head eligible, and the retire pulse appears from edge E+1.
REQ-028 Retire frees the entry (busy=0), head <= head+1, count <= count-1.
REQ-029 Dispatch and retire on the same edge: count is unchanged; when count==16, a retire does not enable dispatch until the next cycle.
REQ-030 A CDB write to the head entry and a retire decision use pre-edge state; the newly done head retires one edge later.
REQ-031 Pulse outputs (commit_valid, store_commit, clr) return to 0 on the next edge without a new event, including while rdy=0.
REQ-032 rdy=0: no dispatch, no CDB capture and no retire; head, tail, count and entries hold.

Reset
REQ-033 rst low asynchronously clears head, tail, count and all busy/done bits, and sets commit_valid, store_commit, clr=0, commit_addr, commit_value, commit_tag, store_tag=0, and redirect_pc=0.
REQ-034 Reset in mid-operation discards all in-flight entries, with no retire pulse.
REQ-035 disp_accept is 0 while rst is low.

Verification
REQ-036 Dispatch 3 register writes (rd=1,2,3), CDB in order tags 2,0,1 (values 0xA,0xB,0xC) -> commits in tag order 0,1,2 with addr 1/2/3 and values 0xB,0xC,0xA, one per cycle.
REQ-037 Dispatch 16 entries without CDB -> disp_accept=0 at count 16, rob_tail=0 after wrap; one completed retire -> accept returns the following cycle, with the new entry tagged 0.
REQ-038 Branch pred_taken=1, alt_pc=0x1004, CDB cdb_taken=0 with 2 younger entries done -> clr pulse with redirect_pc=0x1004, and no commits of the younger entries; afterwards rob_tail=0 and count=0.
REQ-039 Store at the head, done -> store_commit=1, store_tag=head for one cycle, and commit_valid=0.
REQ-040 rdy low for 5 cycles with a done head and a CDB to a busy tag -> no pulses and no state change; after rdy rises, the head retires on the first edge.
REQ-041 rst low asserted mid-stream with 4 busy entries -> outputs 0 immediately; after release rob_tail=0 and disp_accept follows disp_valid.

Source files
------------

// File: rtl/reorder_buffer.sv
// Reorder buffer: 16-entry circular queue that accepts instructions in
// program order, captures out-of-order results from the CDB, and retires
// one completed head entry per cycle. A mispredicted branch at the head
// flushes the whole buffer and emits a redirect.
module reorder_buffer #(
   parameter int ROB_DEPTH = 16,
   parameter int TAG_W     = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             disp_valid,
   input  logic [1:0]       disp_kind,
   input  logic [4:0]       disp_rd,
   input  logic             disp_pred_taken,
   input  logic [31:0]      disp_alt_pc,
   output logic             disp_accept,
   output logic [TAG_W-1:0] rob_tail,
   input  logic             cdb_valid,
   input  logic [TAG_W-1:0] cdb_tag,
   input  logic [31:0]      cdb_value,
   input  logic             cdb_taken,
   output logic             commit_valid,
   output logic [4:0]       commit_addr,
   output logic [31:0]      commit_value,
   output logic [TAG_W-1:0] commit_tag,
   output logic             store_commit,
   output logic [TAG_W-1:0] store_tag,
   output logic             clr,
   output logic [31:0]      redirect_pc
);
   localparam int         CNT_W       = TAG_W + 1;
   localparam logic [1:0] KIND_STORE  = 2'd1;
   localparam logic [1:0] KIND_BRANCH = 2'd2;

   logic [TAG_W-1:0]     head, tail;
   logic [CNT_W-1:0]     count, count_next;
   logic [ROB_DEPTH-1:0] busy, done;

   // Entry payload; only meaningful while the matching busy bit is set.
   logic [1:0]           kind_q  [ROB_DEPTH];
   logic [4:0]           rd_q    [ROB_DEPTH];
   logic [31:0]          value_q [ROB_DEPTH];
   logic [31:0]          alt_q   [ROB_DEPTH];
   logic [ROB_DEPTH-1:0] pred_q, actual_q;

   logic head_ready, do_retire, mispredict, do_disp, cdb_hit;

   // All decisions are taken from pre-edge state; a CDB write to the head
   // only makes it retirable on the following edge.
   assign head_ready  = (count != '0) && busy[head] && done[head];
   assign do_retire   = rdy && head_ready;
   assign mispredict  = do_retire && (kind_q[head] == KIND_BRANCH) &&
                        (actual_q[head] != pred_q[head]);
   // clr is the registered flush pulse, so no dispatch during the cycle after a flush.
   assign disp_accept = disp_valid & rdy & rst & (count < CNT_W'(ROB_DEPTH)) & ~clr;
   // A dispatch landing on the flushing edge is dropped along with everything else.
   assign do_disp     = disp_accept & ~mispredict;
   assign cdb_hit     = rdy & cdb_valid & busy[cdb_tag];
   assign count_next  = count + CNT_W'(do_disp) - CNT_W'(do_retire);
   assign rob_tail    = tail;

   // Queue pointers and per-entry busy/done flags; flush overrides all updates.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         busy  <= '0;
         done  <= '0;
      end else if (rdy) begin
         if (cdb_hit)
            done[cdb_tag] <= 1'b1;
         if (do_disp) begin
            busy[tail] <= 1'b1;
            done[tail] <= 1'b0;
            tail       <= tail + TAG_W'(1);
         end
         if (do_retire) begin
            busy[head] <= 1'b0;
            done[head] <= 1'b0;
            head       <= head + TAG_W'(1);
         end
         count <= count_next;
         if (mispredict) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            busy  <= '0;
            done  <= '0;
         end
      end
   end

   // Entry payload capture at dispatch and at CDB broadcast (no reset needed).
   always_ff @(posedge clk) begin
      if (rdy) begin
         if (cdb_hit) begin
            value_q[cdb_tag]  <= cdb_value;
            actual_q[cdb_tag] <= cdb_taken;
         end
         if (do_disp) begin
            kind_q[tail] <= disp_kind;
            rd_q[tail]   <= disp_rd;
            pred_q[tail] <= disp_pred_taken;
            alt_q[tail]  <= disp_alt_pc;
         end
      end
   end

   // Registered retire outputs; pulses self-clear every edge, even with rdy low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         commit_valid <= 1'b0;
         commit_addr  <= '0;
         commit_value <= '0;
         commit_tag   <= '0;
         store_commit <= 1'b0;
         store_tag    <= '0;
         clr          <= 1'b0;
         redirect_pc  <= '0;
      end else begin
         commit_valid <= 1'b0;
         store_commit <= 1'b0;
         clr          <= 1'b0;
         if (do_retire) begin
            case (kind_q[head])
               KIND_STORE: begin
                  store_commit <= 1'b1;
                  store_tag    <= head;
               end
               KIND_BRANCH: begin
                  if (mispredict) begin
                     clr         <= 1'b1;
                     redirect_pc <= alt_q[head];
                  end
               end
               // Register write, and the reserved encoding treated as one.
               default: begin
                  commit_valid <= 1'b1;
                  commit_addr  <= rd_q[head];
                  commit_value <= value_q[head];
                  commit_tag   <= head;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_reorder_buffer.sv
// Scenario bench for reorder_buffer: expected retire events are queued when
// stimulus is driven and checked by a negedge monitor as pulses appear.
module tb_reorder_buffer;
   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        disp_valid;
   logic [1:0]  disp_kind;
   logic [4:0]  disp_rd;
   logic        disp_pred_taken;
   logic [31:0] disp_alt_pc;
   logic        disp_accept;
   logic [3:0]  rob_tail;
   logic        cdb_valid;
   logic [3:0]  cdb_tag;
   logic [31:0] cdb_value;
   logic        cdb_taken;
   logic        commit_valid;
   logic [4:0]  commit_addr;
   logic [31:0] commit_value;
   logic [3:0]  commit_tag;
   logic        store_commit;
   logic [3:0]  store_tag;
   logic        clr;
   logic [31:0] redirect_pc;

   // kind: 0 register commit, 1 store commit, 2 flush/redirect
   typedef struct {
      logic [1:0]  kind;
      logic [4:0]  addr;
      logic [31:0] data;
      logic [3:0]  tag;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   logic mon_ok;
   int   total = 0;
   int   pass  = 0;

   reorder_buffer #(.ROB_DEPTH(16), .TAG_W(4)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .disp_valid(disp_valid), .disp_kind(disp_kind), .disp_rd(disp_rd),
      .disp_pred_taken(disp_pred_taken), .disp_alt_pc(disp_alt_pc),
      .disp_accept(disp_accept), .rob_tail(rob_tail),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .cdb_taken(cdb_taken),
      .commit_valid(commit_valid), .commit_addr(commit_addr), .commit_value(commit_value),
      .commit_tag(commit_tag), .store_commit(store_commit), .store_tag(store_tag),
      .clr(clr), .redirect_pc(redirect_pc)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [1:0] k, input logic [4:0] a,
                               input logic [31:0] d, input logic [3:0] t);
      exp_t e;
      e.kind = k; e.addr = a; e.data = d; e.tag = t;
      return e;
   endfunction

   // Scoreboard monitor: every retire pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (commit_valid || store_commit || clr) begin
         total++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_pulse: commit=%0b store=%0b clr=%0b ctag=%0d stag=%0d, required no pulse",
                     commit_valid, store_commit, clr, commit_tag, store_tag);
         end else begin
            mon_e = exp_q.pop_front();
            case (mon_e.kind)
               2'd0: mon_ok = commit_valid && !store_commit && !clr && commit_addr === mon_e.addr &&
                              commit_value === mon_e.data && commit_tag === mon_e.tag;
               2'd1: mon_ok = store_commit && !commit_valid && !clr && store_tag === mon_e.tag;
               default: mon_ok = clr && !commit_valid && !store_commit && redirect_pc === mon_e.data;
            endcase
            if (!mon_ok)
               $display("FAIL retire_event: got cv=%0b sc=%0b clr=%0b addr=%0d val=%h ctag=%0d stag=%0d pc=%h, expected kind=%0d addr=%0d data=%h tag=%0d",
                        commit_valid, store_commit, clr, commit_addr, commit_value, commit_tag,
                        store_tag, redirect_pc, mon_e.kind, mon_e.addr, mon_e.data, mon_e.tag);
            else
               pass++;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic dispatch(input logic [1:0] k, input logic [4:0] rd, input logic pt,
                           input logic [31:0] alt);
      disp_valid = 1'b1; disp_kind = k; disp_rd = rd; disp_pred_taken = pt; disp_alt_pc = alt;
      tick();
      disp_valid = 1'b0;
   endtask

   task automatic bcast(input logic [3:0] t, input logic [31:0] v, input logic tk);
      cdb_valid = 1'b1; cdb_tag = t; cdb_value = v; cdb_taken = tk;
      tick();
      cdb_valid = 1'b0;
   endtask

   task automatic wait_empty(input int limit);
      for (int i = 0; i < limit && exp_q.size() != 0; i++) tick();
   endtask

   task automatic apply_reset();
      rst = 1'b0; tick(); tick(); rst = 1'b1; tick();
   endtask

   task automatic test_reset();
      rst = 1'b0; rdy = 1'b1; disp_valid = 1'b1; disp_kind = 2'd0; disp_rd = 5'd0;
      disp_pred_taken = 1'b0; disp_alt_pc = '0; cdb_valid = 1'b0; cdb_tag = '0;
      cdb_value = '0; cdb_taken = 1'b0;
      tick();
      total++; if ({commit_valid, store_commit, clr} !== 3'b000)
         $display("FAIL reset_pulses: got %b expected 000", {commit_valid, store_commit, clr}); else pass++;
      total++; if ({commit_addr, commit_value, commit_tag, store_tag, redirect_pc} !== '0)
         $display("FAIL reset_data: got addr=%0d val=%h ctag=%0d stag=%0d pc=%h expected all 0",
                  commit_addr, commit_value, commit_tag, store_tag, redirect_pc); else pass++;
      total++; if (rob_tail !== 4'd0) $display("FAIL reset_tail: got %0d expected 0", rob_tail); else pass++;
      total++; if (disp_accept !== 1'b0) $display("FAIL reset_accept: got %b expected 0", disp_accept); else pass++;
      disp_valid = 1'b0; rst = 1'b1;
      tick();
      disp_valid = 1'b1; #1;
      total++; if (disp_accept !== 1'b1) $display("FAIL post_reset_accept: got %b expected 1", disp_accept); else pass++;
      disp_valid = 1'b0;
   endtask

   task automatic test_full();
      int acc = 0;
      disp_valid = 1'b1; disp_kind = 2'd0;
      for (int i = 0; i < 16; i++) begin
         disp_rd = 5'(i + 1); #1;
         if (disp_accept) acc++;
         tick();
      end
      total++; if (acc !== 16) $display("FAIL full_accepts: got %0d expected 16", acc); else pass++;
      total++; if (disp_accept !== 1'b0) $display("FAIL full_accept_low: got %b expected 0", disp_accept); else pass++;
      total++; if (rob_tail !== 4'd0) $display("FAIL full_tail_wrap: got %0d expected 0", rob_tail); else pass++;
      exp_q.push_back(mk(2'd0, 5'd1, 32'h100, 4'd0));
      bcast(4'd0, 32'h100, 1'b0);
      total++; if (disp_accept !== 1'b0) $display("FAIL full_accept_before_retire: got %b expected 0", disp_accept); else pass++;
      tick();
      total++; if (disp_accept !== 1'b1) $display("FAIL full_accept_after_retire: got %b expected 1", disp_accept); else pass++;
      total++; if (rob_tail !== 4'd0) $display("FAIL full_new_tag: got %0d expected 0", rob_tail); else pass++;
      disp_rd = 5'd20;
      tick();
      disp_valid = 1'b0;
      total++; if (rob_tail !== 4'd1) $display("FAIL full_tail_after: got %0d expected 1", rob_tail); else pass++;
      total++; if (exp_q.size() !== 0) $display("FAIL full_drain: got %0d pending expected 0", exp_q.size()); else pass++;
      apply_reset();
   endtask

   task automatic test_inorder();
      dispatch(2'd0, 5'd1, 1'b0, '0);
      dispatch(2'd0, 5'd2, 1'b0, '0);
      dispatch(2'd0, 5'd3, 1'b0, '0);
      total++; if (rob_tail !== 4'd3) $display("FAIL inorder_tail: got %0d expected 3", rob_tail); else pass++;
      exp_q.push_back(mk(2'd0, 5'd1, 32'hB, 4'd0));
      exp_q.push_back(mk(2'd0, 5'd2, 32'hC, 4'd1));
      exp_q.push_back(mk(2'd0, 5'd3, 32'hA, 4'd2));
      bcast(4'd2, 32'hA, 1'b0);
      bcast(4'd0, 32'hB, 1'b0);
      bcast(4'd1, 32'hC, 1'b0);
      total++; if (!(commit_valid === 1'b1 && commit_tag === 4'd0))
         $display("FAIL inorder_c0: got cv=%b tag=%0d expected 1/0", commit_valid, commit_tag); else pass++;
      tick();
      total++; if (!(commit_valid === 1'b1 && commit_tag === 4'd1))
         $display("FAIL inorder_c1: got cv=%b tag=%0d expected 1/1", commit_valid, commit_tag); else pass++;
      tick();
      total++; if (!(commit_valid === 1'b1 && commit_tag === 4'd2))
         $display("FAIL inorder_c2: got cv=%b tag=%0d expected 1/2", commit_valid, commit_tag); else pass++;
      wait_empty(10);
      total++; if (exp_q.size() !== 0) $display("FAIL inorder_drain: got %0d pending expected 0", exp_q.size()); else pass++;
   endtask

   task automatic test_store();
      dispatch(2'd1, 5'd0, 1'b0, '0);
      exp_q.push_back(mk(2'd1, 5'd0, 32'd0, 4'd3));
      bcast(4'd3, 32'h1234, 1'b0);
      tick();
      total++; if (!(store_commit === 1'b1 && commit_valid === 1'b0 && store_tag === 4'd3))
         $display("FAIL store_pulse: got sc=%b cv=%b tag=%0d expected 1/0/3", store_commit, commit_valid, store_tag); else pass++;
      tick();
      total++; if (store_commit !== 1'b0) $display("FAIL store_one_cycle: got %b expected 0", store_commit); else pass++;
      wait_empty(10);
      total++; if (exp_q.size() !== 0) $display("FAIL store_drain: got %0d pending expected 0", exp_q.size()); else pass++;
   endtask

   task automatic test_mispredict();
      dispatch(2'd2, 5'd0, 1'b1, 32'h1004);
      dispatch(2'd0, 5'd5, 1'b0, '0);
      dispatch(2'd0, 5'd6, 1'b0, '0);
      bcast(4'd5, 32'h55, 1'b0);
      bcast(4'd6, 32'h66, 1'b0);
      exp_q.push_back(mk(2'd2, 5'd0, 32'h1004, 4'd0));
      disp_valid = 1'b1; disp_kind = 2'd0; disp_rd = 5'd9;
      bcast(4'd4, 32'h0, 1'b0);
      total++; if (rob_tail !== 4'd8) $display("FAIL mp_tail_pre: got %0d expected 8", rob_tail); else pass++;
      tick();
      total++; if (!(clr === 1'b1 && redirect_pc === 32'h1004))
         $display("FAIL mp_clr: got clr=%b pc=%h expected 1/00001004", clr, redirect_pc); else pass++;
      total++; if (rob_tail !== 4'd0) $display("FAIL mp_tail_flush: got %0d expected 0", rob_tail); else pass++;
      total++; if (disp_accept !== 1'b0) $display("FAIL mp_accept_during_clr: got %b expected 0", disp_accept); else pass++;
      tick();
      disp_valid = 1'b0;
      total++; if (!(clr === 1'b0 && rob_tail === 4'd0))
         $display("FAIL mp_after: got clr=%b tail=%0d expected 0/0", clr, rob_tail); else pass++;
      exp_q.push_back(mk(2'd0, 5'd7, 32'h77, 4'd0));
      dispatch(2'd0, 5'd7, 1'b0, '0);
      bcast(4'd0, 32'h77, 1'b0);
      wait_empty(10);
      total++; if (exp_q.size() !== 0) $display("FAIL mp_drain: got %0d pending expected 0", exp_q.size()); else pass++;
   endtask

   task automatic test_rdy_stall();
      dispatch(2'd0, 5'd10, 1'b0, '0);
      dispatch(2'd0, 5'd11, 1'b0, '0);
      bcast(4'd1, 32'h55, 1'b0);
      rdy = 1'b0;
      cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_value = 32'h66; cdb_taken = 1'b0;
      disp_valid = 1'b1; disp_rd = 5'd13; #1;
      total++; if (disp_accept !== 1'b0) $display("FAIL stall_accept: got %b expected 0", disp_accept); else pass++;
      for (int i = 0; i < 5; i++) tick();
      total++; if (rob_tail !== 4'd3) $display("FAIL stall_tail: got %0d expected 3", rob_tail); else pass++;
      exp_q.push_back(mk(2'd0, 5'd10, 32'h55, 4'd1));
      rdy = 1'b1; cdb_valid = 1'b0; disp_valid = 1'b0;
      tick();
      total++; if (!(commit_valid === 1'b1 && commit_tag === 4'd1))
         $display("FAIL stall_release: got cv=%b tag=%0d expected 1/1", commit_valid, commit_tag); else pass++;
      tick(); tick();
      total++; if (exp_q.size() !== 0) $display("FAIL stall_pending: got %0d expected 0", exp_q.size()); else pass++;
      exp_q.push_back(mk(2'd0, 5'd11, 32'h66, 4'd2));
      bcast(4'd2, 32'h66, 1'b0);
      wait_empty(10);
      total++; if (exp_q.size() !== 0) $display("FAIL stall_drain: got %0d pending expected 0", exp_q.size()); else pass++;
   endtask

   task automatic test_branch_correct();
      dispatch(2'd2, 5'd0, 1'b0, 32'hDEAD);
      dispatch(2'd0, 5'd12, 1'b0, '0);
      total++; if (rob_tail !== 4'd5) $display("FAIL br_tail: got %0d expected 5", rob_tail); else pass++;
      bcast(4'd3, 32'h0, 1'b0);
      exp_q.push_back(mk(2'd0, 5'd12, 32'h99, 4'd4));
      bcast(4'd4, 32'h99, 1'b0);
      wait_empty(10);
      total++; if (exp_q.size() !== 0) $display("FAIL br_drain: got %0d pending expected 0", exp_q.size()); else pass++;
   endtask

   task automatic test_reset_midstream();
      for (int i = 0; i < 4; i++) dispatch(2'd0, 5'(i + 1), 1'b0, '0);
      total++; if (rob_tail !== 4'd9) $display("FAIL mid_tail_pre: got %0d expected 9", rob_tail); else pass++;
      #2 rst = 1'b0; disp_valid = 1'b1; #1;
      total++; if ({commit_addr, commit_value, commit_tag, store_tag, redirect_pc} !== '0)
         $display("FAIL mid_data: got addr=%0d val=%h ctag=%0d stag=%0d pc=%h expected all 0",
                  commit_addr, commit_value, commit_tag, store_tag, redirect_pc); else pass++;
      total++; if (rob_tail !== 4'd0) $display("FAIL mid_tail: got %0d expected 0", rob_tail); else pass++;
      total++; if (disp_accept !== 1'b0) $display("FAIL mid_accept: got %b expected 0", disp_accept); else pass++;
      tick();
      rst = 1'b1; disp_valid = 1'b0;
      for (int i = 5; i < 9; i++) bcast(4'(i), 32'(i), 1'b0);
      tick(); tick();
      disp_valid = 1'b1; #1;
      total++; if (disp_accept !== 1'b1) $display("FAIL mid_accept_hi: got %b expected 1", disp_accept); else pass++;
      disp_valid = 1'b0; #1;
      total++; if (disp_accept !== 1'b0) $display("FAIL mid_accept_lo: got %b expected 0", disp_accept); else pass++;
   endtask

   initial begin
      test_reset();
      test_full();
      test_inorder();
      test_store();
      test_mispredict();
      test_rdy_stall();
      test_branch_correct();
      test_reset_midstream();
      tick(); tick();
      total++; if (exp_q.size() !== 0) $display("FAIL final_drain: got %0d pending expected 0", exp_q.size()); else pass++;
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
